// File: rtl/inv_seq_pkg.sv
// Shared types and widths for the INV cell sequencer.
// State encoding, timer width and error-counter width live here.
// No logic, no latency, no backpressure.
package inv_seq_pkg;

    localparam int CNT_W = 4;
    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DPULSE,
        S_SETUP,
        S_CLKP,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

endpackage

// File: rtl/inv_seq_ctrl_if.sv
// Request/response and cell-pin bundle for the INV cell sequencer.
// Pure wiring, zero latency.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
interface inv_seq_ctrl_if;

    logic                          req_valid;
    logic                          req_data;
    logic                          req_ready;
    logic                          d_pulse;
    logic                          clk_pulse;
    logic                          cell_out;
    logic                          rsp_valid;
    logic                          rsp_data;
    logic                          rsp_err;
    logic                          rsp_ready;
    logic [inv_seq_pkg::ERR_W-1:0] err_count;

    modport master (
        output req_valid, req_data, cell_out, rsp_ready,
        input  req_ready, d_pulse, clk_pulse, rsp_valid, rsp_data, rsp_err, err_count
    );

    modport slave (
        input  req_valid, req_data, cell_out, rsp_ready,
        output req_ready, d_pulse, clk_pulse, rsp_valid, rsp_data, rsp_err, err_count
    );

endinterface

// File: rtl/inv_seq_timer.sv
// Loadable 4-bit down-counter timing SETUP, WAIT and HOLD.
// Loads in one cycle; zero flag is combinational from the count.
// No backpressure; stops at zero instead of wrapping.
module inv_seq_timer
    import inv_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/inv_seq_ctrl.sv
// Sequences d/clk pulses into an INV cell and checks its output (macro INV_SEQ_ERRCNT_EN adds err_count).
// Latency: response T_SETUP+OUT_WAIT+3 cycles after request acceptance.
// Backpressure: one transaction at a time; rsp held until rsp_ready, then T_HOLD guard cycles.
module inv_seq_ctrl
    import inv_seq_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int OUT_WAIT = 3,
    parameter int T_HOLD   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    inv_seq_ctrl_if.slave bus
);

    // The timer is loaded in the cycle before a timed state so its count is N-1 on entry.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(OUT_WAIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = (T_HOLD > 0) ? CNT_W'(T_HOLD - 1) : '0;

    state_t           state;
    logic             bit_q;
    logic             cap;
    logic             cap_next;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    inv_seq_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            S_DPULSE: begin tmr_load = 1'b1; tmr_value = SETUP_LD; end
            S_CLKP:   begin tmr_load = 1'b1; tmr_value = WAIT_LD;  end
            S_RESP:   begin tmr_load = 1'b1; tmr_value = HOLD_LD;  end
            default:  ;
        endcase
    end

    assign cap_next = cap | bus.cell_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bit_q         <= 1'b0;
            cap           <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.d_pulse   <= 1'b0;
            bus.clk_pulse <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.d_pulse   <= 1'b0;
            bus.clk_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bit_q         <= bus.req_data;
                        bus.d_pulse   <= bus.req_data;
                        bus.req_ready <= 1'b0;
                        state         <= S_DPULSE;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                S_DPULSE: state <= S_SETUP;
                S_SETUP: begin
                    if (tmr_zero) begin
                        bus.clk_pulse <= 1'b1;
                        state         <= S_CLKP;
                    end
                end
                S_CLKP: begin
                    cap   <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cap <= cap_next;
                    if (tmr_zero) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= cap_next;
                        bus.rsp_err   <= cap_next ^ ~bit_q;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (T_HOLD == 0) begin
                            bus.req_ready <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (tmr_zero) begin
                        bus.req_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INV_SEQ_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state == S_RESP && bus.rsp_ready && bus.rsp_err && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.err_count = err_cnt;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// Directed bench for inv_seq_ctrl: default instance plus a T_SETUP=1/OUT_WAIT=1/T_HOLD=0 instance.
module tb_inv_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

`ifdef INV_SEQ_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    always #5 clk = ~clk;

    inv_seq_ctrl_if a_if ();
    inv_seq_ctrl_if b_if ();

    inv_seq_ctrl u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    inv_seq_ctrl #(.T_SETUP(1), .OUT_WAIT(1), .T_HOLD(0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One request on instance A; cycle numbers count from 1 = cycle after acceptance.
    task automatic run_a(input logic data, input logic [31:0] pat,
                         output int t_d, output int t_c, output int t_r,
                         output int n_d, output int n_c, output int ovl);
        int n;
        t_d = 0; t_c = 0; t_r = 0; n_d = 0; n_c = 0; ovl = 0;
        @(negedge clk);
        a_if.req_valid = 1'b1;
        a_if.req_data  = data;
        n = 0;
        while (!a_if.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_req_ready_before_accept", {31'd0, a_if.req_ready}, 32'd1);
        @(posedge clk);
        #1 a_if.req_valid = 1'b0;
        for (int c = 1; c <= 30 && t_r == 0; c++) begin
            @(negedge clk);
            if (a_if.d_pulse)   begin n_d++; if (t_d == 0) t_d = c; end
            if (a_if.clk_pulse) begin n_c++; if (t_c == 0) t_c = c; end
            if (a_if.d_pulse && a_if.clk_pulse) ovl++;
            if (a_if.rsp_valid) t_r = c;
            a_if.cell_out = pat[c];
        end
        a_if.cell_out = 1'b0;
    endtask

    // Hold rsp_ready low for 'hold' cycles, handshake, then count cycles until req_ready.
    task automatic hs_a(input int hold, output int gap);
        logic d0, e0;
        int   bad;
        d0  = a_if.rsp_data;
        e0  = a_if.rsp_err;
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (a_if.rsp_valid !== 1'b1 || a_if.rsp_data !== d0 ||
                a_if.rsp_err !== e0 || a_if.req_ready !== 1'b0) bad++;
        end
        check("rsp_stable_while_stalled", bad, 0);
        a_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 a_if.rsp_ready = 1'b0;
        gap = 1;
        @(negedge clk);
        check("rsp_valid_drop_after_hs", {31'd0, a_if.rsp_valid}, 32'd0);
        while (!a_if.req_ready && gap < 20) begin
            @(negedge clk);
            gap++;
        end
    endtask

    initial begin
        int td, tc, tr, nd, nc, ov, gap, n, cnt_c, cnt_r;
        int bclk1, bclk2, brsp1, brsp2, brdy6;
        a_if.req_valid = 1'b0; a_if.req_data = 1'b0; a_if.cell_out = 1'b0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_data = 1'b0; b_if.cell_out = 1'b0; b_if.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_req_ready", {31'd0, a_if.req_ready}, 32'd0);
        check("reset_outputs", {27'd0, a_if.d_pulse, a_if.clk_pulse, a_if.rsp_valid,
                                a_if.rsp_data, a_if.rsp_err}, 32'd0);
        check("reset_err_count", {24'd0, a_if.err_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("a_ready_first_edge", {31'd0, a_if.req_ready}, 32'd1);
        check("b_ready_first_edge", {31'd0, b_if.req_ready}, 32'd1);

        // data=1, cell_out low throughout
        run_a(1'b1, 32'h0, td, tc, tr, nd, nc, ov);
        check("t1_d_cycle", td, 1);
        check("t1_clk_cycle", tc, 4);
        check("t1_rsp_cycle", tr, 8);
        check("t1_d_count", nd, 1);
        check("t1_clk_count", nc, 1);
        check("t1_overlap", ov, 0);
        check("t1_rsp_data", {31'd0, a_if.rsp_data}, 32'd0);
        check("t1_rsp_err", {31'd0, a_if.rsp_err}, 32'd0);
        hs_a(0, gap);
        check("t1_ready_gap", gap, 2);

        // data=0, cell_out high in cycle 6 only; stall response 5 cycles
        run_a(1'b0, 32'h40, td, tc, tr, nd, nc, ov);
        check("t2_d_count", nd, 0);
        check("t2_clk_cycle", tc, 4);
        check("t2_rsp_cycle", tr, 8);
        check("t2_rsp_data", {31'd0, a_if.rsp_data}, 32'd1);
        check("t2_rsp_err", {31'd0, a_if.rsp_err}, 32'd0);
        hs_a(5, gap);
        check("t2_ready_gap", gap, 2);

        // data=0, cell_out low -> error
        run_a(1'b0, 32'h0, td, tc, tr, nd, nc, ov);
        check("t3_rsp_data", {31'd0, a_if.rsp_data}, 32'd0);
        check("t3_rsp_err", {31'd0, a_if.rsp_err}, 32'd1);
        hs_a(0, gap);
        check("t3_err_count", {24'd0, a_if.err_count}, ERR_EN);

        // cell_out high only outside WAIT (cycles 1..4) must be ignored
        run_a(1'b1, 32'h1E, td, tc, tr, nd, nc, ov);
        check("t4_rsp_data", {31'd0, a_if.rsp_data}, 32'd0);
        check("t4_rsp_err", {31'd0, a_if.rsp_err}, 32'd0);
        hs_a(0, gap);

        // cell_out high in last WAIT cycle (7), then first WAIT cycle (5)
        run_a(1'b1, 32'h80, td, tc, tr, nd, nc, ov);
        check("t5_rsp_data", {31'd0, a_if.rsp_data}, 32'd1);
        check("t5_rsp_err", {31'd0, a_if.rsp_err}, 32'd1);
        hs_a(0, gap);
        run_a(1'b1, 32'h20, td, tc, tr, nd, nc, ov);
        check("t6_rsp_data", {31'd0, a_if.rsp_data}, 32'd1);
        check("t6_rsp_err", {31'd0, a_if.rsp_err}, 32'd1);
        hs_a(0, gap);
        check("t6_err_count", {24'd0, a_if.err_count}, 3 * ERR_EN);

        // reset asserted in cycle 3 of a transaction
        @(negedge clk);
        a_if.req_valid = 1'b1;
        a_if.req_data  = 1'b1;
        n = 0;
        while (!a_if.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 a_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {26'd0, a_if.req_ready, a_if.d_pulse, a_if.clk_pulse,
                                 a_if.rsp_valid, a_if.rsp_data, a_if.rsp_err}, 32'd0);
        check("midrst_err_count", {24'd0, a_if.err_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_first_edge", {31'd0, a_if.req_ready}, 32'd1);
        cnt_c = 0;
        cnt_r = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_if.clk_pulse) cnt_c++;
            if (a_if.rsp_valid) cnt_r++;
        end
        check("midrst_no_clk_pulse", cnt_c, 0);
        check("midrst_no_rsp", cnt_r, 0);

`ifdef INV_SEQ_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            run_a(1'b0, 32'h0, td, tc, tr, nd, nc, ov);
            hs_a(0, gap);
        end
        check("err_count_saturate", {24'd0, a_if.err_count}, 32'd255);
`endif

        // instance B: back-to-back requests with short timing
        b_if.req_data = 1'b1;
        @(negedge clk);
        b_if.req_valid = 1'b1;
        n = 0;
        while (!b_if.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        bclk1 = 0; bclk2 = 0; brsp1 = 0; brsp2 = 0; brdy6 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (b_if.clk_pulse) begin
                if (bclk1 == 0) bclk1 = c;
                else if (bclk2 == 0) bclk2 = c;
            end
            if (b_if.rsp_valid) begin
                if (brsp1 == 0) brsp1 = c;
                else if (brsp2 == 0) brsp2 = c;
            end
            if (c == 6) brdy6 = b_if.req_ready;
            b_if.rsp_ready = b_if.rsp_valid;
            if (c == 12) b_if.req_valid = 1'b0;
        end
        b_if.rsp_ready = 1'b0;
        check("b_clk_cycle_1", bclk1, 3);
        check("b_rsp_cycle_1", brsp1, 5);
        check("b_ready_after_hs", brdy6, 1);
        check("b_clk_cycle_2", bclk2, 9);
        check("b_rsp_cycle_2", brsp2, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
